// File: rtl/clock_divider_sequencer.sv
// Clock prescaler and reset sequencer for the RGBW controller core.
// Produces a runtime-programmable divided clock with a rising-edge tick,
// holds the downstream reset for a fixed startup window, and supports
// parking the divided clock low and a soft restart of the whole sequence.
module clock_divider_sequencer #(
    parameter int unsigned DIV_W          = 8,
    parameter int unsigned STARTUP_CYCLES = 128,
    parameter int unsigned STARTUP_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             en,
    input  logic             restart,
    output logic             clk_presc,
    output logic             tick,
    output logic             rst_n_out,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_PARKED  = 2'd3
    } state_t;

    localparam logic [STARTUP_W-1:0] STARTUP_LAST = STARTUP_W'(STARTUP_CYCLES);

    state_t               state_q;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     ratio_q;
    logic [STARTUP_W-1:0] startup_cnt;

    logic                 div_tc_c;
    logic                 park_c;
    logic [DIV_W-1:0]     div_cnt_nxt_c;
    logic [DIV_W-1:0]     ratio_nxt_c;
    logic                 presc_nxt_c;
    logic                 tick_nxt_c;

    assign state    = state_q;
    assign div_tc_c = (div_cnt == ratio_q);
    // Park only at the boundary that would start a new high half-period.
    assign park_c   = div_tc_c && !clk_presc && !en;

    // Free-running divider step; the ratio is sampled only at half-period boundaries.
    always_comb begin
        div_cnt_nxt_c = div_cnt + DIV_W'(1);
        ratio_nxt_c   = ratio_q;
        presc_nxt_c   = clk_presc;
        tick_nxt_c    = 1'b0;
        if (div_tc_c) begin
            div_cnt_nxt_c = '0;
            ratio_nxt_c   = div_ratio;
            presc_nxt_c   = ~clk_presc;
            tick_nxt_c    = ~clk_presc;
        end
    end

    // Sequencer FSM with registered divider and reset outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            div_cnt     <= '0;
            ratio_q     <= '0;
            startup_cnt <= '0;
            clk_presc   <= 1'b0;
            tick        <= 1'b0;
            rst_n_out   <= 1'b0;
        end else if (restart && (state_q != ST_INIT)) begin
            state_q     <= ST_INIT;
            div_cnt     <= '0;
            startup_cnt <= '0;
            clk_presc   <= 1'b0;
            tick        <= 1'b0;
            rst_n_out   <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    ratio_q     <= div_ratio;
                    div_cnt     <= '0;
                    startup_cnt <= '0;
                    clk_presc   <= 1'b0;
                    rst_n_out   <= 1'b0;
                    state_q     <= ST_STARTUP;
                end
                ST_STARTUP: begin
                    div_cnt   <= div_cnt_nxt_c;
                    ratio_q   <= ratio_nxt_c;
                    clk_presc <= presc_nxt_c;
                    tick      <= tick_nxt_c;
                    if (startup_cnt == STARTUP_LAST) begin
                        rst_n_out   <= 1'b1;
                        startup_cnt <= '0;
                        state_q     <= ST_ACTIVE;
                    end else begin
                        startup_cnt <= startup_cnt + STARTUP_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (park_c) begin
                        div_cnt <= '0;
                        state_q <= ST_PARKED;
                    end else begin
                        div_cnt   <= div_cnt_nxt_c;
                        ratio_q   <= ratio_nxt_c;
                        clk_presc <= presc_nxt_c;
                        tick      <= tick_nxt_c;
                    end
                end
                ST_PARKED: begin
                    clk_presc <= 1'b0;
                    div_cnt   <= '0;
                    if (en) begin
                        ratio_q <= div_ratio;
                        state_q <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_divider_sequencer.sv
// Self-checking bench for clock_divider_sequencer.
module tb_clock_divider_sequencer;

    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] div_ratio;
    logic             en;
    logic             restart;
    logic             clk_presc;
    logic             tick;
    logic             rst_n_out;
    logic [1:0]       state;

    clock_divider_sequencer #(
        .DIV_W(DIV_W),
        .STARTUP_CYCLES(128),
        .STARTUP_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .div_ratio(div_ratio),
        .en(en),
        .restart(restart),
        .clk_presc(clk_presc),
        .tick(tick),
        .rst_n_out(rst_n_out),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ratio;
        logic       en;
        logic       restart;
        logic       presc;
        logic       tick;
        logic       rstn;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        logic       presc;
        logic       tick;
        logic       rstn;
        logic [1:0] st;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[44];
    int   checks = 0;
    int   errors = 0;

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic compare_front();
        exp_t x;
        x = sb_q.pop_front();
        checks++;
        if ({clk_presc, tick, rst_n_out, state} !== {x.presc, x.tick, x.rstn, x.st}) begin
            errors++;
            $display("FAIL %s: got presc=%b tick=%b rstn=%b state=%0d, want presc=%b tick=%b rstn=%b state=%0d",
                     x.name, clk_presc, tick, rst_n_out, state, x.presc, x.tick, x.rstn, x.st);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, compare after the edge.
    task automatic step(input logic rst, input logic [7:0] r, input logic e, input logic rs,
                        input logic xp, input logic xt, input logic xr, input logic [1:0] xs,
                        input string name);
        exp_t x;
        reset     = rst;
        div_ratio = r;
        en        = e;
        restart   = rs;
        x.presc = xp;
        x.tick  = xt;
        x.rstn  = xr;
        x.st    = xs;
        x.name  = name;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Startup with div_ratio=0: edge k (k=1 is the INIT->STARTUP edge) toggles on even k.
    task automatic startup_ratio0(input int last_edge, input string tag);
        for (int k = 1; k <= last_edge; k++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0,
                 (k >= 2) && (k % 2 == 0), (k >= 2) && (k % 2 == 0),
                 k >= 130, (k >= 130) ? 2'd2 : 2'd1,
                 $sformatf("%s_edge%0d", tag, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t1;
        int t2;
        int hi_cnt;
        int rel;
        int dbl;
        logic prev_tick;

        // Divide-by-8 then divide-by-4 after a mid-high-phase ratio change.
        for (int j = 0; j < 24; j++) begin
            tbl[j].ratio   = (j <= 13) ? 8'd3 : 8'd1;
            tbl[j].en      = 1'b1;
            tbl[j].restart = 1'b0;
            tbl[j].rstn    = 1'b1;
            tbl[j].st      = 2'd2;
            if (j < 16) begin
                tbl[j].presc = ((j / 4) % 2) == 1;
                tbl[j].tick  = (j == 4) || (j == 12);
            end else begin
                tbl[j].presc = (((j - 16) / 2) % 2) == 1;
                tbl[j].tick  = (j == 18) || (j == 22);
            end
        end
        // Park after the high phase completes, then resume.
        for (int k = 0; k < 20; k++) begin
            tbl[24+k].ratio   = 8'd2;
            tbl[24+k].en      = !((k >= 4) && (k <= 12));
            tbl[24+k].restart = 1'b0;
            tbl[24+k].rstn    = 1'b1;
            tbl[24+k].st      = ((k >= 9) && (k <= 12)) ? 2'd3 : 2'd2;
            tbl[24+k].presc   = ((k >= 3) && (k <= 5)) || ((k >= 16) && (k <= 18));
            tbl[24+k].tick    = (k == 3) || (k == 16);
        end

        // Reset for three cycles.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, $sformatf("reset%0d", i));

        // Startup: release on the 130th edge after reset drops, then 4 ACTIVE edges.
        startup_ratio0(134, "startup");

        for (int i = 0; i < 44; i++)
            step(1'b0, tbl[i].ratio, tbl[i].en, tbl[i].restart,
                 tbl[i].presc, tbl[i].tick, tbl[i].rstn, tbl[i].st, $sformatf("tbl%0d", i));

        // Restart exactly on a rising terminal count: restart wins, no tick.
        step(1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, "pre_restart0");
        step(1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, "pre_restart1");
        step(1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "restart_tc");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "restart_init_exit");
        n = 1;
        while (!rst_n_out && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("restart_release_edge", n, 130);

        // Reset and restart together during STARTUP.
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "restart2");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "restart2_init_exit");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, "restart2_edge2");
        step(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "reset_and_restart");
        step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "reset_hold");

        // Restart on the startup-completion edge: reset stays asserted.
        startup_ratio0(129, "startup2");
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "restart_at_release");

        // Maximum ratio: period 512, 256 high, first rise at INIT edge + 256.
        reset     = 1'b0;
        restart   = 1'b0;
        en        = 1'b1;
        div_ratio = 8'hFF;
        t1 = 0; t2 = 0; hi_cnt = 0; rel = 0; dbl = 0;
        prev_tick = 1'b0;
        for (int k = 1; k <= 1000 && t2 == 0; k++) begin
            @(posedge clk);
            #1;
            if (rst_n_out && rel == 0) rel = k;
            if (tick && prev_tick) dbl++;
            if (tick) begin
                if (t1 == 0) t1 = k;
                else t2 = k;
            end
            if (t1 != 0 && t2 == 0 && clk_presc) hi_cnt++;
            prev_tick = tick;
        end
        check_int("maxratio_release_edge", rel, 130);
        check_int("maxratio_first_rise", t1, 257);
        check_int("maxratio_period", t2 - t1, 512);
        check_int("maxratio_high_cycles", hi_cnt, 256);
        check_int("maxratio_double_tick", dbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
